// File: rtl/case_6_prod_accum_pkg.sv
// ---------------------------------------------------------------------------
// case_6_prod_accum_pkg
// Shared definitions for the product accumulator: FSM state encoding and
// the default widths used by the interface, adder and top level.
// ---------------------------------------------------------------------------
package case_6_prod_accum_pkg;

    localparam int DEF_DIN_WIDTH = 26;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

endpackage : case_6_prod_accum_pkg

// File: rtl/case_6_prod_accum_if.sv
// ---------------------------------------------------------------------------
// case_6_prod_accum_if
// Bundles the job control (ap_start/ap_idle/ap_done/len), the product input
// stream (din/din_valid/din_ready), the sum output (dout/dout_valid/
// dout_ready) and the overflow flag of the product accumulator.
//   master : the side that launches jobs, feeds products, takes the sum
//   slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface case_6_prod_accum_if
    import case_6_prod_accum_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
);

    logic                        ap_start;
    logic                        ap_idle;
    logic                        ap_done;
    logic [LEN_WIDTH-1:0]        len;
    logic signed [DIN_WIDTH-1:0] din;
    logic                        din_valid;
    logic                        din_ready;
    logic signed [ACC_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        dout_ready;
    logic                        ovf;

    modport master (
        output ap_start, len, din, din_valid, dout_ready,
        input  ap_idle, ap_done, din_ready, dout, dout_valid, ovf
    );

    modport slave (
        input  ap_start, len, din, din_valid, dout_ready,
        output ap_idle, ap_done, din_ready, dout, dout_valid, ovf
    );

endinterface : case_6_prod_accum_if

// File: rtl/case_6_sat_add.sv
// ---------------------------------------------------------------------------
// case_6_sat_add
// Combinational accumulator adder: i_acc + sign-extended i_din.
// Build option CASE_6_PROD_ACCUM_SAT_EN:
//   defined   : sum computed one bit wider; on overflow the result clamps to
//               the most positive / most negative ACC_WIDTH value and o_ovf=1
//   undefined : sum wraps modulo 2^ACC_WIDTH and o_ovf is constant 0
// Ports:
//   i_acc  [ACC_WIDTH] current accumulator (signed)
//   i_din  [DIN_WIDTH] incoming product (signed)
//   o_sum  [ACC_WIDTH] next accumulator value
//   o_ovf              overflow on this addition
// ---------------------------------------------------------------------------
module case_6_sat_add
    import case_6_prod_accum_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic signed [DIN_WIDTH-1:0] i_din,
    output logic signed [ACC_WIDTH-1:0] o_sum,
    output logic                        o_ovf
);

`ifdef CASE_6_PROD_ACCUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] w_wide;

    // Both operands are signed, so the size casts sign-extend.
    assign w_wide = (ACC_WIDTH+1)'(i_acc) + (ACC_WIDTH+1)'(i_din);

    // The extra top bit disagreeing with the ACC sign bit means the true
    // sum does not fit; the extra bit carries the true sign.
    assign o_ovf = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

    always_comb begin
        o_sum = w_wide[ACC_WIDTH-1:0];
        if (o_ovf) begin
            o_sum = w_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign o_sum = i_acc + ACC_WIDTH'(i_din);
    assign o_ovf = 1'b0;
`endif

endmodule : case_6_sat_add

// File: rtl/case_6_prod_accum.sv
// ---------------------------------------------------------------------------
// case_6_prod_accum
// Sums a run-time number (len) of signed products from the case_6
// multiplier and presents the total on a held valid/ready output, with an
// ap-style start/idle/done job protocol.
// Build option CASE_6_PROD_ACCUM_SAT_EN selects saturating accumulation
// with a sticky ovf flag; without it the accumulator wraps and ovf is 0.
// Ports:
//   ap_clk   clock, rising edge
//   ap_rst   synchronous active-high reset; aborts any running job
//   s_if     slave side of case_6_prod_accum_if (job control, din stream,
//            dout stream, ovf)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for ap_start; len latched and acc/cnt/ovf cleared
// ST_ACCUM | din_ready=1, one product added per accepted beat
// ST_OUT   | dout_valid=1, sum held until dout_ready
// ---------------------------------------------------------------------------
module case_6_prod_accum
    import case_6_prod_accum_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    case_6_prod_accum_if.slave  s_if
);

    state_e                      r_state;
    state_e                      w_next_state;
    logic [LEN_WIDTH-1:0]        r_len;
    logic [LEN_WIDTH-1:0]        r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ovf;
    logic                        r_done;

    logic                        w_start;
    logic                        w_beat;
    logic                        w_last;
    logic                        w_out_hs;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_ovf;

    assign w_start  = (r_state == ST_IDLE)  && s_if.ap_start;
    assign w_beat   = (r_state == ST_ACCUM) && s_if.din_valid;
    assign w_out_hs = (r_state == ST_OUT)   && s_if.dout_ready;
    // len is never 0 while in ST_ACCUM, so len-1 cannot underflow here.
    assign w_last   = (r_cnt == (r_len - LEN_WIDTH'(1)));

    case_6_sat_add #(
        .DIN_WIDTH (DIN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_acc (r_acc),
        .i_din (s_if.din),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (s_if.ap_start) begin
                    w_next_state = (s_if.len == '0) ? ST_OUT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_beat && w_last) begin
                    w_next_state = ST_OUT;
                end
            end
            ST_OUT: begin
                if (s_if.dout_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_out_hs;
            if (w_start) begin
                r_len <= s_if.len;
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_beat) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + LEN_WIDTH'(1);
                r_ovf <= r_ovf | w_ovf;
            end
        end
    end

    // All handshake outputs decode from the state register only, so there
    // is no combinational path from din_valid or dout_ready.
    assign s_if.ap_idle    = (r_state == ST_IDLE);
    assign s_if.din_ready  = (r_state == ST_ACCUM);
    assign s_if.dout_valid = (r_state == ST_OUT);
    assign s_if.ap_done    = r_done;
    assign s_if.dout       = r_acc;
    assign s_if.ovf        = r_ovf;

endmodule : case_6_prod_accum

// File: tb/tb_case_6_prod_accum.sv
module tb_case_6_prod_accum;

    localparam int  DW   = 26;
    localparam int  AW   = 27;
    localparam int  LW   = 8;
    localparam longint AMAX = 64'sd67108863;
    localparam longint AMIN = -64'sd67108864;
    localparam longint AMOD = 64'sd134217728;

    logic ap_clk;
    logic ap_rst;

    int n_checks = 0;
    int n_errors = 0;

    case_6_prod_accum_if #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    case_6_prod_accum #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .s_if   (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Job-level model: tracks whether a job is open, how many of its terms
    // have been consumed, and the mathematically expected sum.
    bit     m_busy = 1'b0;
    int     m_len  = 0;
    int     m_cnt  = 0;
    longint m_sum  = 0;
    bit     m_ovf  = 1'b0;
    bit     m_done = 1'b0;

    always @(negedge ap_clk) begin
        longint s;
        if (ap_rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_sum  = 0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
        end else begin
            chk("ap_done",    longint'(bus.ap_done),    longint'(m_done));
            chk("ap_idle",    longint'(bus.ap_idle),    longint'(!m_busy));
            chk("din_ready",  longint'(bus.din_ready),  longint'(m_busy && m_cnt < m_len));
            chk("dout_valid", longint'(bus.dout_valid), longint'(m_busy && m_cnt == m_len));
            chk("ovf",        longint'(bus.ovf),        longint'(m_ovf));
            if (m_busy && m_cnt == m_len) begin
                chk("dout", longint'($signed(bus.dout)), m_sum);
            end
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.ap_start) begin
                    m_busy = 1'b1;
                    m_len  = int'(bus.len);
                    m_cnt  = 0;
                    m_sum  = 0;
                    m_ovf  = 1'b0;
                end
            end else if (m_cnt < m_len) begin
                if (bus.din_valid) begin
                    s = m_sum + longint'($signed(bus.din));
`ifdef CASE_6_PROD_ACCUM_SAT_EN
                    if (s > AMAX) begin
                        s = AMAX;
                        m_ovf = 1'b1;
                    end else if (s < AMIN) begin
                        s = AMIN;
                        m_ovf = 1'b1;
                    end
`else
                    s = s % AMOD;
                    if (s < 0) s = s + AMOD;
                    if (s > AMAX) s = s - AMOD;
`endif
                    m_sum = s;
                    m_cnt++;
                end
            end else if (bus.dout_ready) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    task automatic run_job(input int n, input longint v[8], input int gap, input int owait,
                           output longint res, output bit res_ovf);
        int to;
        bus.len      = LW'(n);
        bus.ap_start = 1'b1;
        tick();
        bus.ap_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            bus.din       = v[i][DW-1:0];
            bus.din_valid = 1'b1;
            to = 0;
            while (!bus.din_ready && to < 20) begin
                tick();
                to++;
            end
            if (to >= 20) chk("din_ready_timeout", 0, 1);
            tick();
            bus.din_valid = 1'b0;
        end
        chk("dout_valid_latency", longint'(bus.dout_valid), 1);
        repeat (owait) tick();
        res     = longint'($signed(bus.dout));
        res_ovf = bus.ovf;
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        chk("ap_done_pulse", longint'(bus.ap_done), 1);
        tick();
        chk("ap_done_clear", longint'(bus.ap_done), 0);
    endtask

    initial begin
        longint v[8];
        longint res;
        bit     rov;

        ap_rst         = 1'b1;
        bus.ap_start   = 1'b0;
        bus.len        = '0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;

        repeat (2) tick();
        chk("rst_ap_idle",    longint'(bus.ap_idle),    1);
        chk("rst_ap_done",    longint'(bus.ap_done),    0);
        chk("rst_din_ready",  longint'(bus.din_ready),  0);
        chk("rst_dout_valid", longint'(bus.dout_valid), 0);
        chk("rst_dout",       longint'($signed(bus.dout)), 0);
        chk("rst_ovf",        longint'(bus.ovf),        0);
        ap_rst = 1'b0;
        tick();

        v = '{100, -250, 7, 0, 0, 0, 0, 0};
        run_job(3, v, 0, 0, res, rov);
        chk("basic_sum", res, -143);

        v = '{1000, -2000, 3000, 0, 0, 0, 0, 0};
        run_job(3, v, 2, 5, res, rov);
        chk("gap_sum", res, 2000);

        v = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_job(0, v, 0, 0, res, rov);
        chk("zero_len_sum", res, 0);

        v = '{33554431, 33554431, 33554431, 0, 0, 0, 0, 0};
        run_job(3, v, 0, 1, res, rov);
`ifdef CASE_6_PROD_ACCUM_SAT_EN
        chk("ovf_sum",  res, 67108863);
        chk("ovf_flag", longint'(rov), 1);
`else
        chk("ovf_sum",  res, -33554435);
        chk("ovf_flag", longint'(rov), 0);
`endif

        v = '{-5000000, 12345, -1, 33554431, -33554432, 0, 0, 0};
        run_job(5, v, 1, 2, res, rov);
        chk("mixed_sum",  res, -4987657);
        chk("mixed_ovf",  longint'(rov), 0);

        // Abort a 4-term job after two beats.
        bus.len       = LW'(4);
        bus.ap_start  = 1'b1;
        tick();
        bus.ap_start  = 1'b0;
        bus.din       = DW'(11);
        bus.din_valid = 1'b1;
        tick();
        tick();
        bus.din_valid = 1'b0;
        ap_rst        = 1'b1;
        tick();
        ap_rst        = 1'b0;
        chk("abort_idle",  longint'(bus.ap_idle), 1);
        chk("abort_done",  longint'(bus.ap_done), 0);
        chk("abort_dout",  longint'($signed(bus.dout)), 0);
        repeat (3) tick();
        chk("abort_no_done", longint'(bus.ap_done), 0);

        v = '{5, 0, 0, 0, 0, 0, 0, 0};
        run_job(1, v, 0, 0, res, rov);
        chk("after_abort_sum", res, 5);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_case_6_prod_accum
